seven_seg_reader: RTL

//  Recovers BCD digits from a multiplexed, active-low 7-segment display bus (segments + digit anodes).

---
 rtl/seven_seg_pkg.sv | 46 ++++
 rtl/seven_seg_pattern_decoder.sv | 37 +++
 rtl/seven_seg_reader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment reader: active-low segment patterns,
// FSM state encodings and the decoded-digit record.
package seven_seg_pkg;

  localparam int CODE_W = 4;

  // Segment order a..g maps to bit6..bit0, 0 = lit
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              blank;
    logic [CODE_W-1:0] code;
  } seg_dec_t;

  function automatic seg_dec_t mk_dec(input logic v, input logic b, input logic [CODE_W-1:0] c);
    seg_dec_t d;
    d.valid = v;
    d.blank = b;
    d.code  = c;
    return d;
  endfunction

endpackage

// File: rtl/seven_seg_pattern_decoder.sv
// Combinational inverse segment map: seg[6:0] -> {valid, blank, code}.
// Hex letters A..F are only accepted when SEVEN_SEG_READER_HEX_EN is defined.
module seven_seg_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output seg_dec_t   dec
);

  // Pattern lookup; anything outside the table decodes as invalid
  always_comb begin
    dec = mk_dec(1'b0, 1'b0, 4'h0);
    case (seg)
      SEG_0:     dec = mk_dec(1'b1, 1'b0, 4'h0);
      SEG_1:     dec = mk_dec(1'b1, 1'b0, 4'h1);
      SEG_2:     dec = mk_dec(1'b1, 1'b0, 4'h2);
      SEG_3:     dec = mk_dec(1'b1, 1'b0, 4'h3);
      SEG_4:     dec = mk_dec(1'b1, 1'b0, 4'h4);
      SEG_5:     dec = mk_dec(1'b1, 1'b0, 4'h5);
      SEG_6:     dec = mk_dec(1'b1, 1'b0, 4'h6);
      SEG_7:     dec = mk_dec(1'b1, 1'b0, 4'h7);
      SEG_8:     dec = mk_dec(1'b1, 1'b0, 4'h8);
      SEG_9:     dec = mk_dec(1'b1, 1'b0, 4'h9);
      SEG_BLANK: dec = mk_dec(1'b1, 1'b1, 4'h0);
`ifdef SEVEN_SEG_READER_HEX_EN
      SEG_A:     dec = mk_dec(1'b1, 1'b0, 4'hA);
      SEG_B:     dec = mk_dec(1'b1, 1'b0, 4'hB);
      SEG_C:     dec = mk_dec(1'b1, 1'b0, 4'hC);
      SEG_D:     dec = mk_dec(1'b1, 1'b0, 4'hD);
      SEG_E:     dec = mk_dec(1'b1, 1'b0, 4'hE);
      SEG_F:     dec = mk_dec(1'b1, 1'b0, 4'hF);
`endif
      default:   dec = mk_dec(1'b0, 1'b0, 4'h0);
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Recovers BCD digit frames from a multiplexed active-low 7-segment bus.
// Optional hex letter support via SEVEN_SEG_READER_HEX_EN (see pattern decoder).
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [6:0]                   seg_in,
  input  logic [NUM_DIGITS-1:0]        an_in,
  output logic [CODE_W*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]        blank_out,
  output logic                         frame_valid,
  output logic                         err_pulse
);

  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_TGT  = CNT_W'(STABLE_CNT);
  localparam logic [NUM_DIGITS-1:0] AN_ZERO  = {NUM_DIGITS{1'b0}};

  logic [6:0]                   seg_r, prev_seg_r;
  logic [NUM_DIGITS-1:0]        an_r, prev_an_r, an_act_s;
  logic                         an_valid_s, same_s, commit_s, commit_ok_s, frame_done_s;
  state_t                       state_r, state_nxt_s;
  logic [CNT_W-1:0]             cnt_r, cnt_nxt_s;
  seg_dec_t                     dec_s;
  logic [CODE_W*NUM_DIGITS-1:0] slots_r, slots_nxt_s;
  logic [NUM_DIGITS-1:0]        blank_slot_r, blank_slot_nxt_s, seen_r, seen_nxt_s;

  // Input capture: everything downstream works on this registered copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_BLANK;
      an_r  <= {NUM_DIGITS{1'b1}};
    end else begin
      seg_r <= seg_in;
      an_r  <= an_in;
    end
  end

  // A usable sample has exactly one anode driven low
  always_comb begin
    an_act_s     = ~an_r;
    an_valid_s   = (an_act_s != AN_ZERO) &&
                   ((an_act_s & (an_act_s - NUM_DIGITS'(1))) == AN_ZERO);
    same_s       = (an_r == prev_an_r) && (seg_r == prev_seg_r);
    frame_done_s = &seen_r;
  end

  seven_seg_pattern_decoder u_dec (
    .seg (seg_r),
    .dec (dec_s)
  );

  // Stability FSM next-state; the stable count reaching target is the commit
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    commit_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (an_valid_s) begin
          state_nxt_s = S_TRACK;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      S_TRACK: begin
        if (!an_valid_s) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (same_s) begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt_s   = CNT_ONE;
        end
      end
      S_HOLD: begin
        if (!an_valid_s) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (same_s) begin
          state_nxt_s = S_HOLD;
        end else begin
          state_nxt_s = S_TRACK;
          cnt_nxt_s   = CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
    if ((state_nxt_s == S_TRACK) && (cnt_nxt_s == CNT_TGT)) begin
      commit_s    = 1'b1;
      state_nxt_s = S_HOLD;
    end else begin
      commit_s    = 1'b0;
    end
  end

  // FSM state, counter and the last valid sample for stability comparison
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      cnt_r      <= CNT_ZERO;
      prev_seg_r <= SEG_BLANK;
      prev_an_r  <= {NUM_DIGITS{1'b1}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (an_valid_s) begin
        prev_seg_r <= seg_r;
        prev_an_r  <= an_r;
      end
    end
  end

  // Slot and seen-mask update; a completed frame clears seen but keeps a same-cycle commit
  always_comb begin
    commit_ok_s      = commit_s & dec_s.valid;
    slots_nxt_s      = slots_r;
    blank_slot_nxt_s = blank_slot_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (commit_ok_s && an_act_s[i]) begin
        slots_nxt_s[CODE_W*i +: CODE_W] = dec_s.code;
        blank_slot_nxt_s[i]             = dec_s.blank;
      end else begin
        slots_nxt_s[CODE_W*i +: CODE_W] = slots_r[CODE_W*i +: CODE_W];
        blank_slot_nxt_s[i]             = blank_slot_r[i];
      end
    end
    seen_nxt_s = (frame_done_s ? AN_ZERO : seen_r) | (commit_ok_s ? an_act_s : AN_ZERO);
  end

  // Slot storage and frame output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_r      <= {(CODE_W*NUM_DIGITS){1'b0}};
      blank_slot_r <= AN_ZERO;
      seen_r       <= AN_ZERO;
      digits_out   <= {(CODE_W*NUM_DIGITS){1'b0}};
      blank_out    <= AN_ZERO;
      frame_valid  <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      slots_r      <= slots_nxt_s;
      blank_slot_r <= blank_slot_nxt_s;
      seen_r       <= seen_nxt_s;
      frame_valid  <= frame_done_s;
      err_pulse    <= commit_s & ~dec_s.valid;
      if (frame_done_s) begin
        digits_out <= slots_r;
        blank_out  <= blank_slot_r;
      end
    end
  end

endmodule
